// File: rtl/piano_pkg.sv
// Shared definitions for the piano audio path: note/octave codes, the
// middle-octave half-period table and the tone FSM state encoding.
package piano_pkg;

    localparam logic [3:0] NOTE_REST = 4'd0;
    localparam logic [3:0] NOTE_DO   = 4'd1;
    localparam logic [3:0] NOTE_RE   = 4'd2;
    localparam logic [3:0] NOTE_MI   = 4'd3;
    localparam logic [3:0] NOTE_FA   = 4'd4;
    localparam logic [3:0] NOTE_SOL  = 4'd5;
    localparam logic [3:0] NOTE_LA   = 4'd6;
    localparam logic [3:0] NOTE_SI   = 4'd7;

    localparam logic [1:0] OCT_LOW  = 2'b00;
    localparam logic [1:0] OCT_MID  = 2'b01;
    localparam logic [1:0] OCT_HIGH = 2'b10;

    // Half-period clock counts at 100 MHz, middle octave, C..B.
    localparam logic [17:0] HALF_TABLE [7] = '{
        18'd191113, 18'd170262, 18'd151686, 18'd143173,
        18'd127551, 18'd113636, 18'd101239
    };

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    function automatic logic is_rest(input logic [3:0] note);
        return (note == NOTE_REST) || (note > NOTE_SI);
    endfunction

    function automatic logic [1:0] norm_oct(input logic [1:0] oct);
        return (oct == 2'b11) ? OCT_MID : oct;
    endfunction

    function automatic logic [17:0] base_half(input logic [3:0] note);
        logic [17:0] b;
        case (note)
            NOTE_DO:  b = HALF_TABLE[0];
            NOTE_RE:  b = HALF_TABLE[1];
            NOTE_MI:  b = HALF_TABLE[2];
            NOTE_FA:  b = HALF_TABLE[3];
            NOTE_SOL: b = HALF_TABLE[4];
            NOTE_LA:  b = HALF_TABLE[5];
            NOTE_SI:  b = HALF_TABLE[6];
            default:  b = '0;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/tone_generator_if.sv
// Note/octave/mute request from the mode controller and the buzzer/status
// signals returned by the tone generator.
interface tone_generator_if;
    logic [3:0] note_in;
    logic [1:0] octave_in;
    logic       mute;
    logic       speaker;
    logic       playing;
    logic       note_strobe;

    modport master (
        output note_in, octave_in, mute,
        input  speaker, playing, note_strobe
    );

    modport slave (
        input  note_in, octave_in, mute,
        output speaker, playing, note_strobe
    );
endinterface

// File: rtl/tone_generator_half_period_lut.sv
// Combinational note/octave to half-period count, scaled by SIM_SHIFT.
module half_period_lut
    import piano_pkg::*;
#(
    parameter int SIM_SHIFT = 0,
    parameter int CNT_W     = 20
) (
    input  logic [3:0]       note_i,
    input  logic [1:0]       oct_i,
    output logic [CNT_W-1:0] half_o
);

    logic [CNT_W-1:0] base;

    always_comb begin
        base   = '0;
        half_o = '0;
        if (!is_rest(note_i)) begin
            base = CNT_W'(base_half(note_i)) >> SIM_SHIFT;
        end
        case (norm_oct(oct_i))
            OCT_LOW:  half_o = base << 1;
            OCT_HIGH: half_o = base >> 1;
            default:  half_o = base;
        endcase
    end

endmodule

// File: rtl/tone_generator.sv
// Square-wave tone generator: note changes take effect only at half-period
// boundaries so the buzzer never sees a runt pulse.
module tone_generator
    import piano_pkg::*;
#(
    parameter int SIM_SHIFT = 0,
    parameter int CNT_W     = 20
) (
    input  logic            clk,
    input  logic            reset,
    tone_generator_if.slave bus
);

    logic [3:0]       note_q;
    logic [1:0]       oct_q;
    logic [3:0]       last_note_q;
    logic [1:0]       last_oct_q;
    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cur_half_q;
    logic [CNT_W-1:0] half_d;
    logic             spk_q;
    logic             playing_q;
    logic             strobe_q;
    logic             rest_d;
    logic             changed_d;
    logic             half_end_d;

    half_period_lut #(
        .SIM_SHIFT (SIM_SHIFT),
        .CNT_W     (CNT_W)
    ) u_lut (
        .note_i (note_q),
        .oct_i  (oct_q),
        .half_o (half_d)
    );

    assign rest_d     = is_rest(note_q);
    assign changed_d  = (note_q != last_note_q) || (norm_oct(oct_q) != last_oct_q);
    assign half_end_d = (cnt_q == cur_half_q - CNT_W'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            note_q      <= NOTE_REST;
            oct_q       <= OCT_MID;
            last_note_q <= NOTE_REST;
            last_oct_q  <= OCT_MID;
            state_q     <= IDLE;
            cnt_q       <= '0;
            cur_half_q  <= '0;
            spk_q       <= 1'b0;
            playing_q   <= 1'b0;
            strobe_q    <= 1'b0;
        end else begin
            note_q   <= bus.note_in;
            oct_q    <= bus.octave_in;
            strobe_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (!rest_d) begin
                        state_q     <= HIGH;
                        cur_half_q  <= half_d;
                        spk_q       <= 1'b1;
                        playing_q   <= 1'b1;
                        strobe_q    <= 1'b1;
                        last_note_q <= note_q;
                        last_oct_q  <= norm_oct(oct_q);
                    end
                end
                HIGH: begin
                    // A rest waits for the high half to finish.
                    if (half_end_d) begin
                        cnt_q <= '0;
                        spk_q <= 1'b0;
                        if (rest_d) begin
                            state_q   <= IDLE;
                            playing_q <= 1'b0;
                        end else begin
                            state_q     <= LOW;
                            cur_half_q  <= half_d;
                            strobe_q    <= changed_d;
                            last_note_q <= note_q;
                            last_oct_q  <= norm_oct(oct_q);
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                LOW: begin
                    // Speaker is already low, so a rest can stop immediately.
                    if (rest_d) begin
                        state_q   <= IDLE;
                        cnt_q     <= '0;
                        playing_q <= 1'b0;
                    end else if (half_end_d) begin
                        state_q     <= HIGH;
                        cnt_q       <= '0;
                        spk_q       <= 1'b1;
                        cur_half_q  <= half_d;
                        strobe_q    <= changed_d;
                        last_note_q <= note_q;
                        last_oct_q  <= norm_oct(oct_q);
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    spk_q   <= 1'b0;
                end
            endcase
        end
    end

    // Mute gates only the pin; timing keeps running so unmute stays in phase.
    assign bus.speaker     = spk_q & ~bus.mute;
    assign bus.playing     = playing_q;
    assign bus.note_strobe = strobe_q;

endmodule

// File: tb/tb_tone_generator.sv
// Directed bench for tone_generator at SIM_SHIFT=8: table of single notes
// plus hand-written sequences for octave/note changes, rests, mute, reset.
module tb_tone_generator;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    tone_generator_if tif ();

    tone_generator #(
        .SIM_SHIFT (8),
        .CNT_W     (20)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (tif)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int strobe_cnt = 0;

    always @(posedge clk) begin
        if (tif.note_strobe === 1'b1) strobe_cnt <= strobe_cnt + 1;
    end

    typedef struct {
        logic [3:0] note;
        logic [1:0] oct;
        int         half;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset         = 1'b1;
        tif.note_in   = 4'd0;
        tif.octave_in = 2'b01;
        tif.mute      = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_rise(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (tif.speaker !== 1'b1 && lat < 20);
    endtask

    task automatic measure(input logic lvl, output int n);
        n = 0;
        while (tif.speaker === lvl && n < 4000) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic silent_for(input string name, input int cycles);
        int bad;
        bad = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (tif.speaker !== 1'b0 || tif.playing !== 1'b0) bad++;
        end
        check(name, bad, 0);
    endtask

    // Measure a high half while changing note/octave after `at` samples.
    task automatic high_with_change(input int at, input logic [3:0] nn,
                                    input logic [1:0] no, output int n);
        n = 0;
        while (tif.speaker === 1'b1 && n < 4000) begin
            n++;
            if (n == at) begin
                tif.note_in   = nn;
                tif.octave_in = no;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        #3ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, n, s0, err, perr;
        logic exp_spk;

        vecs[0] = '{4'd6, 2'b01, 443};
        vecs[1] = '{4'd1, 2'b00, 1492};
        vecs[2] = '{4'd1, 2'b10, 373};
        vecs[3] = '{4'd6, 2'b11, 443};
        vecs[4] = '{4'd7, 2'b10, 197};
        vecs[5] = '{4'd3, 2'b00, 1184};
        vecs[6] = '{4'd5, 2'b01, 498};
        vecs[7] = '{4'd4, 2'b10, 279};
        vecs[8] = '{4'd9, 2'b01, 0};
        vecs[9] = '{4'd0, 2'b01, 0};

        do_reset();
        check("reset_speaker", int'(tif.speaker), 0);
        check("reset_playing", int'(tif.playing), 0);
        check("reset_strobe", int'(tif.note_strobe), 0);

        for (int i = 0; i < 10; i++) begin
            do_reset();
            s0 = strobe_cnt;
            tif.note_in   = vecs[i].note;
            tif.octave_in = vecs[i].oct;
            if (vecs[i].half == 0) begin
                silent_for($sformatf("v%0d_rest_silent", i), 30);
            end else begin
                wait_rise(lat);
                check($sformatf("v%0d_latency", i), lat, 2);
                check($sformatf("v%0d_rise_strobe", i), int'(tif.note_strobe), 1);
                check($sformatf("v%0d_rise_playing", i), int'(tif.playing), 1);
                measure(1'b1, n);
                check($sformatf("v%0d_high_len", i), n, vecs[i].half);
                measure(1'b0, n);
                check($sformatf("v%0d_low_len", i), n, vecs[i].half);
                check($sformatf("v%0d_same_note_strobe", i), int'(tif.note_strobe), 0);
                repeat (3) @(negedge clk);
                check($sformatf("v%0d_strobe_count", i), strobe_cnt - s0, 1);
            end
        end

        // Octave switch low -> high mid-half.
        do_reset();
        s0 = strobe_cnt;
        tif.note_in = 4'd1; tif.octave_in = 2'b00;
        wait_rise(lat);
        high_with_change(100, 4'd1, 2'b10, n);
        check("oct_sw_high_len", n, 1492);
        check("oct_sw_strobe", int'(tif.note_strobe), 1);
        measure(1'b0, n);
        check("oct_sw_low_len", n, 373);
        measure(1'b1, n);
        check("oct_sw_high2_len", n, 373);
        repeat (3) @(negedge clk);
        check("oct_sw_strobe_count", strobe_cnt - s0, 2);

        // Note change 1 -> 6 mid-half.
        do_reset();
        s0 = strobe_cnt;
        tif.note_in = 4'd1; tif.octave_in = 2'b01;
        wait_rise(lat);
        high_with_change(300, 4'd6, 2'b01, n);
        check("chg_high_len", n, 746);
        measure(1'b0, n);
        check("chg_low_len", n, 443);
        measure(1'b1, n);
        check("chg_high2_len", n, 443);
        repeat (3) @(negedge clk);
        check("chg_strobe_count", strobe_cnt - s0, 2);

        // Rest asserted mid-HIGH: high half completes.
        do_reset();
        tif.note_in = 4'd6; tif.octave_in = 2'b01;
        wait_rise(lat);
        high_with_change(200, 4'd0, 2'b01, n);
        check("rest_high_len", n, 443);
        check("rest_high_playing", int'(tif.playing), 0);
        silent_for("rest_high_silent", 30);

        // Rest asserted mid-LOW: idle on the next cycle.
        do_reset();
        tif.note_in = 4'd6; tif.octave_in = 2'b01;
        wait_rise(lat);
        measure(1'b1, n);
        repeat (100) @(negedge clk);
        tif.note_in = 4'd0;
        @(negedge clk);
        check("rest_low_playing_before", int'(tif.playing), 1);
        @(negedge clk);
        check("rest_low_playing_after", int'(tif.playing), 0);
        silent_for("rest_low_silent", 30);

        // Mute for 1000 cycles; phase must be preserved.
        do_reset();
        tif.note_in = 4'd6; tif.octave_in = 2'b01;
        wait_rise(lat);
        err = 0; perr = 0;
        for (int k = 1; k < 3000; k++) begin
            @(negedge clk);
            if (k == 100)  tif.mute = 1'b1;
            if (k == 1100) tif.mute = 1'b0;
            #1;
            exp_spk = (k >= 100 && k < 1100) ? 1'b0 : (((k / 443) % 2) == 0);
            if (tif.speaker !== exp_spk) err++;
            if (tif.playing !== 1'b1) perr++;
        end
        check("mute_phase_errors", err, 0);
        check("mute_playing_errors", perr, 0);

        // Reset mid-HIGH, then an out-of-range note stays silent.
        do_reset();
        tif.note_in = 4'd6; tif.octave_in = 2'b01;
        wait_rise(lat);
        repeat (50) @(negedge clk);
        reset = 1'b1;
        tif.note_in = 4'd15;
        @(negedge clk);
        check("rst_mid_speaker", int'(tif.speaker), 0);
        check("rst_mid_playing", int'(tif.playing), 0);
        check("rst_mid_strobe", int'(tif.note_strobe), 0);
        reset = 1'b0;
        s0 = strobe_cnt;
        silent_for("note15_silent", 100);
        check("note15_no_strobe", strobe_cnt - s0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
